// File: rtl/svreal_add_pkg.sv
// Shared types and elaboration-time helpers for the svreal fixed-point adder.
package svreal_add_pkg;

  localparam int CALC_W = 64;

  typedef logic signed [CALC_W-1:0] calc_t;

  // S1 -> S2 stage: operands already aligned to the common exponent
  typedef struct packed {
    logic  valid;
    calc_t a;
    calc_t b;
  } s1_t;

  function automatic int exp_min(input int x, input int y, input int z);
    int m;
    m = (x < y) ? x : y;
    return (m < z) ? m : z;
  endfunction

  function automatic int aligned_width(input int w, input int e, input int emin);
    return w + e - emin;
  endfunction

  function automatic calc_t sat_max(input int w);
    return (calc_t'(1) <<< (w - 1)) - calc_t'(1);
  endfunction

  function automatic calc_t sat_min(input int w);
    return -(calc_t'(1) <<< (w - 1));
  endfunction

  // Half-LSB bias for a right shift of sh bits; zero when nothing is shifted out
  function automatic calc_t round_bias(input int sh);
    if (sh > 0) begin
      return calc_t'(1) <<< (sh - 1);
    end else begin
      return calc_t'(0);
    end
  endfunction

endpackage

// File: rtl/svreal_sync_fifo.sv
// Synchronous FIFO with combinational head read and async active-high reset.
module svreal_sync_fifo #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_r;
  logic             do_push;
  logic             do_pop;

  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == CNT_W'(0));
  assign do_pop  = pop && !empty;
  // A push into a full FIFO is only legal when the head leaves in the same cycle
  assign do_push = push && (!full || pop);
  assign dout    = mem[rd_ptr];
  assign count   = count_r;

  // Storage array
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/svreal_add_responder.sv
// Fixed-point c = a + b with align/add/requantize pipeline and credit-based output FIFO.
// Optional macro SVREAL_ADD_ROUND_EN: round half-up on the requantizing right shift.
module svreal_add_responder
  import svreal_add_pkg::*;
#(
  parameter int A_WIDTH    = 16,
  parameter int A_EXP      = -8,
  parameter int B_WIDTH    = 17,
  parameter int B_EXP      = -9,
  parameter int C_WIDTH    = 18,
  parameter int C_EXP      = -10,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [A_WIDTH-1:0] a_value,
  input  logic [B_WIDTH-1:0] b_value,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [C_WIDTH-1:0] c_value,
  output logic               ovf,
  input  logic               clr_ovf
);

  localparam int E      = exp_min(A_EXP, B_EXP, C_EXP);
  localparam int SH_A   = A_EXP - E;
  localparam int SH_B   = B_EXP - E;
  localparam int SH_C   = C_EXP - E;
  localparam int A_AL_W = aligned_width(A_WIDTH, A_EXP, E);
  localparam int B_AL_W = aligned_width(B_WIDTH, B_EXP, E);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam calc_t C_MAX = sat_max(C_WIDTH);
  localparam calc_t C_MIN = sat_min(C_WIDTH);
`ifdef SVREAL_ADD_ROUND_EN
  localparam calc_t RND = round_bias(SH_C);
`else
  localparam calc_t RND = calc_t'(0);
`endif

  s1_t                 s1_r;
  logic signed [A_AL_W-1:0] a_al_s;
  logic signed [B_AL_W-1:0] b_al_s;
  calc_t               sum_s;
  calc_t               shifted_s;
  logic [C_WIDTH-1:0]  c_next_s;
  logic                sat_s;
  logic                in_fire_s;
  logic                out_fire_s;
  logic [C_WIDTH-1:0]  fifo_dout;
  logic [CNT_W-1:0]    fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CNT_W:0]      credit_s;
  logic [C_WIDTH-1:0]  last_r;

  assign a_al_s     = A_AL_W'(signed'(a_value)) <<< SH_A;
  assign b_al_s     = B_AL_W'(signed'(b_value)) <<< SH_B;
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;
  // Buffered plus in-flight results must never exceed FIFO space
  assign credit_s   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_r.valid};
  assign in_ready   = (credit_s < (CNT_W + 1)'(FIFO_DEPTH));
  assign out_valid  = !fifo_empty;
  assign c_value    = fifo_empty ? last_r : fifo_dout;

  // S1: capture operands aligned to the common exponent
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_r <= '0;
    end else begin
      s1_r.valid <= in_fire_s;
      if (in_fire_s) begin
        s1_r.a <= calc_t'(a_al_s);
        s1_r.b <= calc_t'(b_al_s);
      end
    end
  end

  // S2: exact add, requantize to c's exponent, saturate
  always_comb begin
    sum_s     = s1_r.a + s1_r.b + RND;
    shifted_s = sum_s >>> SH_C;
    if (shifted_s > C_MAX) begin
      c_next_s = C_MAX[C_WIDTH-1:0];
      sat_s    = 1'b1;
    end else if (shifted_s < C_MIN) begin
      c_next_s = C_MIN[C_WIDTH-1:0];
      sat_s    = 1'b1;
    end else begin
      c_next_s = shifted_s[C_WIDTH-1:0];
      sat_s    = 1'b0;
    end
  end

  svreal_sync_fifo #(
    .WIDTH (C_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (s1_r.valid),
    .din   (c_next_s),
    .pop   (out_fire_s),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Sticky overflow flag; a new saturation beats a clear in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (s1_r.valid && sat_s) begin
      ovf <= 1'b1;
    end else if (clr_ovf) begin
      ovf <= 1'b0;
    end else begin
      ovf <= ovf;
    end
  end

  // Holds the most recently popped result so c_value is stable while empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_r <= '0;
    end else if (out_fire_s) begin
      last_r <= fifo_dout;
    end else begin
      last_r <= last_r;
    end
  end

endmodule
